multicycle_controller: RTL and testbench

Main control state machine for the multi-cycle MIPS datapath. It fetches and decodes each instruction over several cycles, drives the datapath mux selects and write enables, and supplies the 3-bit ALUOp to the ALU control unit. That unit turns ALUOp plus the instruction's function field into the 4-bit ALU command. The block sits between the instruction register opcode field, the shared instruction/data memory handshake and the datapath.

---
 rtl/multicycle_controller.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multi-cycle MIPS datapath. Each instruction is
// fetched, decoded and executed over several cycles; this block drives the
// datapath mux selects, write enables and the 3-bit ALUOp for ALU control.
//
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   opcode          : instruction register bits [31:26]
//   zero            : ALU zero flag (qualified in the datapath with pc_write_cond)
//   mem_ready       : memory completes the current access this cycle
//   mem_read/write  : memory requests
//   i_or_d          : memory address select (0 = PC, 1 = ALUOut)
//   ir_write        : instruction register load
//   pc_write        : unconditional PC load
//   pc_write_cond   : PC load qualified by zero
//   pc_source       : 00 ALU result, 01 ALUOut, 10 jump target
//   alu_src_a/b     : ALU operand selects
//   alu_op          : 000 R-type, 001 sub, 010 OR, 011 add
//   reg_dst         : write register select (0 = rt, 1 = rd)
//   mem_to_reg      : write-back select (0 = ALUOut, 1 = MDR)
//   reg_write       : register file write enable
//   illegal_op      : one-cycle pulse when decode sees an unsupported opcode
//   state_dbg       : current state encoding
// ---------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    START  = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;

  // The branch decision itself happens in the datapath (pc_write_cond AND
  // zero), so the flag is only routed through here for interface symmetry.
  logic unused_zero;
  assign unused_zero = zero;

  // The opcode is captured only in DECODE so that later states (MEMADR,
  // IEXEC) are immune to the instruction register input changing.
  always_comb begin
    state_d  = state_q;
    opcode_d = (state_q == DECODE) ? opcode : opcode_q;
    case (state_q)
      START:  state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_RTYPE:         state_d = REXEC;
          OP_BEQ:           state_d = BEQ;
          OP_ADDI, OP_ORI:  state_d = IEXEC;
          OP_J:             state_d = JUMP;
          default:          state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (opcode_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      REXEC:  state_d = RWB;
      RWB:    state_d = FETCH;
      BEQ:    state_d = FETCH;
      IEXEC:  state_d = IWB;
      IWB:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = START;
    endcase
  end

  // State and captured opcode; reset abandons any in-flight memory access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= START;
      opcode_q <= 6'b000000;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Moore-style decode of the state, except ir_write/pc_write in FETCH which
  // follow mem_ready so the IR and PC load exactly once per fetch.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b011;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b011;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ORI, OP_J: illegal_op = 1'b0;
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      REXEC: begin
        alu_src_a = 1'b1;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode_q == OP_ORI) ? 3'b010 : 3'b011;
      end
      IWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for the multi-cycle control FSM. Each cycle the state and
// the full packed control word are compared with hand-written expectations.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  // Expected control words per state, taken straight from the state table.
  localparam ctrl_t EXP_ZERO       = '{default: '0};
  localparam ctrl_t EXP_FETCH_WAIT = '{mem_read: 1'b1, alu_src_b: 2'b01, alu_op: 3'b011, default: '0};
  localparam ctrl_t EXP_FETCH_RDY  = '{mem_read: 1'b1, ir_write: 1'b1, pc_write: 1'b1,
                                       alu_src_b: 2'b01, alu_op: 3'b011, default: '0};
  localparam ctrl_t EXP_DECODE     = '{alu_src_b: 2'b11, alu_op: 3'b011, default: '0};
  localparam ctrl_t EXP_DECODE_ILL = '{alu_src_b: 2'b11, alu_op: 3'b011, illegal_op: 1'b1, default: '0};
  localparam ctrl_t EXP_MEMADR     = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b011, default: '0};
  localparam ctrl_t EXP_MEMRD      = '{mem_read: 1'b1, i_or_d: 1'b1, default: '0};
  localparam ctrl_t EXP_MEMWB      = '{reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
  localparam ctrl_t EXP_MEMWR      = '{mem_write: 1'b1, i_or_d: 1'b1, default: '0};
  localparam ctrl_t EXP_REXEC      = '{alu_src_a: 1'b1, default: '0};
  localparam ctrl_t EXP_RWB        = '{reg_write: 1'b1, reg_dst: 1'b1, default: '0};
  localparam ctrl_t EXP_BEQ        = '{alu_src_a: 1'b1, alu_op: 3'b001, pc_write_cond: 1'b1,
                                       pc_source: 2'b01, default: '0};
  localparam ctrl_t EXP_IEXEC_ADD  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b011, default: '0};
  localparam ctrl_t EXP_IEXEC_OR   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b010, default: '0};
  localparam ctrl_t EXP_IWB        = '{reg_write: 1'b1, default: '0};
  localparam ctrl_t EXP_JUMP       = '{pc_write: 1'b1, pc_source: 2'b10, default: '0};

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state_dbg;
  ctrl_t      ctrl_obs;

  int compareCount  = 0;
  int mismatchCount = 0;

  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .illegal_op    (illegal_op),
    .state_dbg     (state_dbg)
  );

  assign ctrl_obs = '{mem_read: mem_read, mem_write: mem_write, i_or_d: i_or_d,
                      ir_write: ir_write, pc_write: pc_write, pc_write_cond: pc_write_cond,
                      pc_source: pc_source, alu_src_a: alu_src_a, alu_src_b: alu_src_b,
                      alu_op: alu_op, reg_dst: reg_dst, mem_to_reg: mem_to_reg,
                      reg_write: reg_write, illegal_op: illegal_op};

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs for the current cycle (called just after a rising edge).
  task automatic applyStimulus(input logic [5:0] opc, input logic rdy, input logic zflag,
                               input logic rst_in);
    opcode    = opc;
    mem_ready = rdy;
    zero      = zflag;
    rst       = rst_in;
  endtask

  // Let the combinational outputs settle, compare state and control word,
  // then advance one clock and step just past the edge.
  task automatic checkCycle(input string tag, input logic [3:0] exp_state, input ctrl_t exp_ctrl);
    #1;
    checkOutput($sformatf("%s_state", tag), {28'b0, state_dbg}, {28'b0, exp_state});
    checkOutput($sformatf("%s_ctrl", tag), {14'b0, ctrl_obs}, {14'b0, exp_ctrl});
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(6'b000000, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Power-on reset: START with every output low, FETCH right after.
    checkCycle("por_start", 4'd0, EXP_ZERO);
    applyStimulus(6'b000000, 1'b1, 1'b0, 1'b0);
    checkCycle("por_start2", 4'd0, EXP_ZERO);

    // R-type: 1,2,7,8,1.
    checkCycle("r_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("r_decode", 4'd2, EXP_DECODE);
    checkCycle("r_rexec",  4'd7, EXP_REXEC);
    checkCycle("r_rwb",    4'd8, EXP_RWB);

    // lw with 3 stall cycles in MEMRD; opcode changes after DECODE are ignored.
    applyStimulus(6'b100011, 1'b1, 1'b0, 1'b0);
    checkCycle("lw_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("lw_decode", 4'd2, EXP_DECODE);
    applyStimulus(6'b101011, 1'b1, 1'b0, 1'b0);
    checkCycle("lw_memadr", 4'd3, EXP_MEMADR);
    applyStimulus(6'b101011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) checkCycle($sformatf("lw_memrd_stall%0d", i), 4'd4, EXP_MEMRD);
    applyStimulus(6'b101011, 1'b1, 1'b0, 1'b0);
    checkCycle("lw_memrd_rdy", 4'd4, EXP_MEMRD);
    checkCycle("lw_memwb",     4'd5, EXP_MEMWB);

    // sw with a FETCH stall and a MEMWR stall.
    applyStimulus(6'b101011, 1'b0, 1'b0, 1'b0);
    checkCycle("sw_fetch_wait", 4'd1, EXP_FETCH_WAIT);
    applyStimulus(6'b101011, 1'b1, 1'b0, 1'b0);
    checkCycle("sw_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("sw_decode", 4'd2, EXP_DECODE);
    applyStimulus(6'b100011, 1'b1, 1'b0, 1'b0);
    checkCycle("sw_memadr", 4'd3, EXP_MEMADR);
    applyStimulus(6'b100011, 1'b0, 1'b0, 1'b0);
    checkCycle("sw_memwr_stall", 4'd6, EXP_MEMWR);
    applyStimulus(6'b100011, 1'b1, 1'b0, 1'b0);
    checkCycle("sw_memwr_rdy", 4'd6, EXP_MEMWR);

    // beq taken then not taken: both return to FETCH after 3 cycles.
    applyStimulus(6'b000100, 1'b1, 1'b1, 1'b0);
    checkCycle("beq1_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("beq1_decode", 4'd2, EXP_DECODE);
    checkCycle("beq1_beq",    4'd9, EXP_BEQ);
    applyStimulus(6'b000100, 1'b1, 1'b0, 1'b0);
    checkCycle("beq0_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("beq0_decode", 4'd2, EXP_DECODE);
    checkCycle("beq0_beq",    4'd9, EXP_BEQ);

    // addi: IEXEC must use the captured opcode, not the live input.
    applyStimulus(6'b001000, 1'b1, 1'b0, 1'b0);
    checkCycle("addi_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("addi_decode", 4'd2, EXP_DECODE);
    applyStimulus(6'b001101, 1'b1, 1'b0, 1'b0);
    checkCycle("addi_iexec",  4'd10, EXP_IEXEC_ADD);
    checkCycle("addi_iwb",    4'd11, EXP_IWB);

    // ori.
    applyStimulus(6'b001101, 1'b1, 1'b0, 1'b0);
    checkCycle("ori_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("ori_decode", 4'd2, EXP_DECODE);
    applyStimulus(6'b001000, 1'b1, 1'b0, 1'b0);
    checkCycle("ori_iexec",  4'd10, EXP_IEXEC_OR);
    checkCycle("ori_iwb",    4'd11, EXP_IWB);

    // j.
    applyStimulus(6'b000010, 1'b1, 1'b0, 1'b0);
    checkCycle("j_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("j_decode", 4'd2, EXP_DECODE);
    checkCycle("j_jump",   4'd12, EXP_JUMP);

    // Illegal opcode: one-cycle pulse in DECODE, then straight back to FETCH.
    applyStimulus(6'b111111, 1'b1, 1'b0, 1'b0);
    checkCycle("ill_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("ill_decode", 4'd2, EXP_DECODE_ILL);
    applyStimulus(6'b111111, 1'b0, 1'b0, 1'b0);
    checkCycle("ill_refetch", 4'd1, EXP_FETCH_WAIT);

    // Reset in the middle of a stalled lw read, held for two edges.
    applyStimulus(6'b100011, 1'b1, 1'b0, 1'b0);
    checkCycle("rst_fetch",  4'd1, EXP_FETCH_RDY);
    checkCycle("rst_decode", 4'd2, EXP_DECODE);
    checkCycle("rst_memadr", 4'd3, EXP_MEMADR);
    applyStimulus(6'b100011, 1'b0, 1'b0, 1'b0);
    checkCycle("rst_memrd", 4'd4, EXP_MEMRD);
    applyStimulus(6'b100011, 1'b0, 1'b0, 1'b1);
    checkCycle("rst_memrd_hit", 4'd4, EXP_MEMRD);
    checkCycle("rst_hold",      4'd0, EXP_ZERO);
    applyStimulus(6'b100011, 1'b1, 1'b0, 1'b0);
    checkCycle("rst_release", 4'd0, EXP_ZERO);
    checkCycle("rst_fetch2",  4'd1, EXP_FETCH_RDY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
